// File: rtl/calc_seq.sv
// Calculator command sequencer: queues {clear, opcode, operand} commands and
// runs each through the shared ALU, writing the 16-bit result back to the accumulator.
module calc_seq #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 0
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_clr,
  input  logic [3:0]  i_cmd_op,
  input  logic [15:0] i_cmd_data,
  input  logic        i_flush,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result,
  output logic [15:0] o_acc,
  output logic        o_acc_zero,
  output logic        o_ovf,
  output logic        o_done,
  output logic        o_busy,
  output logic [15:0] o_op_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  logic [20:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_wait;
  logic [3:0]    w_wait_next;
  logic          r_cur_clr;
  logic [3:0]    r_cur_op;
  logic [15:0]   r_cur_data;
  logic [15:0]   r_acc;
  logic          r_ovf;
  logic          r_done;
  logic [15:0]   r_op_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wb;
  logic          w_ovf;
  logic [20:0]   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // Ready looks only at registered occupancy so it never combinationally depends on a pop.
  assign w_push  = i_cmd_valid && !w_full && !i_flush;
  assign w_wb    = (r_state == S_WB) && !i_flush;
  assign w_head  = r_mem[r_rptr];
  assign w_ovf   = (|i_alu_result[31:15]) && !(&i_alu_result[31:15]);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_cmd_clr, i_cmd_op, i_cmd_data};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_wait_next  = 4'(ALU_LAT);
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_wait == 4'd0) begin
          w_state_next = S_WB;
        end else begin
          w_wait_next = r_wait - 4'd1;
        end
      end
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_next = S_IDLE;
      w_pop        = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_cur_clr  <= 1'b0;
      r_cur_op   <= '0;
      r_cur_data <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_op_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_done  <= w_wb;
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_pop) begin
        r_cur_clr  <= w_head[20];
        r_cur_op   <= w_head[19:16];
        r_cur_data <= w_head[15:0];
      end
      if (w_wb) begin
        r_acc    <= r_cur_clr ? 16'h0 : i_alu_result[15:0];
        r_ovf    <= !r_cur_clr && w_ovf;
        r_op_cnt <= r_op_cnt + 16'd1;
      end
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_alu_op    = r_cur_op;
  assign o_alu_op1   = {{16{r_acc[15]}}, r_acc};
  assign o_alu_op2   = {{16{r_cur_data[15]}}, r_cur_data};
  assign o_acc       = r_acc;
  assign o_acc_zero  = (r_acc == 16'h0);
  assign o_ovf       = r_ovf;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;
  assign o_op_cnt    = r_op_cnt;

endmodule
